// File: rtl/gui_defs_pkg.sv
// ---------------------------------------------------------------------------
// gui_defs_pkg
// Shared definitions for the GUI output stage:
//   - RGB pixel geometry (12-bit {R,G,B}, 4 bits per channel)
//   - scene sequencer state encodings
//   - fade depth (number of dimming steps down to black)
//   - shift_channel(): dims one colour channel by a fade level
// ---------------------------------------------------------------------------
package gui_defs_pkg;

  localparam int RGB_W       = 12;
  localparam int CH_W        = 4;
  localparam int NUM_CH      = 3;
  localparam int FADE_LEVELS = 4;
  localparam int LEVEL_W     = 3;

  typedef enum logic [1:0] {
    ST_MENU     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2,
    ST_MAP      = 2'd3
  } scene_state_e;

  // Level 0 leaves the channel untouched; any level at or beyond the fade
  // depth yields black so an out-of-range level can never leak colour.
  function automatic logic [CH_W-1:0] shift_channel(input logic [CH_W-1:0]    ch,
                                                    input logic [LEVEL_W-1:0] level);
    logic [CH_W-1:0] res;
    if (level >= LEVEL_W'(FADE_LEVELS)) begin
      res = {CH_W{1'b0}};
    end else begin
      res = ch >> level;
    end
    return res;
  endfunction

endpackage

// File: rtl/screen_scene_ctrl_rgb_fade_shift.sv
// ---------------------------------------------------------------------------
// rgb_fade_shift
// Combinational dimmer: logically right-shifts each 4-bit channel of a
// 12-bit RGB pixel by the fade level (0..4, 4 = black).
// Ports:
//   rgb_in   in  12  source pixel {R,G,B}
//   level    in   3  fade level
//   rgb_out  out 12  dimmed pixel
// ---------------------------------------------------------------------------
module rgb_fade_shift
  import gui_defs_pkg::*;
(
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [LEVEL_W-1:0] level,
  output logic [RGB_W-1:0]   rgb_out
);

  // Dim the three channels independently so no bits bleed across channels.
  always_comb begin
    rgb_out = {RGB_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      rgb_out[c*CH_W +: CH_W] = shift_channel(rgb_in[c*CH_W +: CH_W], level);
    end
  end

endmodule

// File: rtl/screen_scene_ctrl.sv
// ---------------------------------------------------------------------------
// screen_scene_ctrl
// Scene sequencer for the GUI output stage. Chooses the menu or map RGB
// stream for the VGA port and switches between them only on frame
// boundaries, fading out to black and back in, FRAMES_PER_STEP frames per
// fade level. With SKIP_FADE=1 the swap happens one frame boundary after
// the transition starts, with no dimming.
// Parameters:
//   FRAMES_PER_STEP  frames held at each fade level (1..255)
//   SKIP_FADE        1 = swap at the next frame boundary, no fade
// Ports:
//   clk          in   1  pixel clock
//   rst          in   1  asynchronous active-high reset
//   hblnk_in     in   1  horizontal blank, aligned with rgb inputs
//   vblnk_in     in   1  vertical blank, aligned with rgb inputs
//   rgb_menu_in  in  12  menu pixel
//   rgb_map_in   in  12  map pixel
//   start_req    in   1  pulse: leave menu, enter map
//   back_req     in   1  pulse: leave map, enter menu
//   rgb_out      out 12  registered pixel (1 clk latency)
//   scene_sel    out  1  0 = menu, 1 = map
//   busy         out  1  transition in progress
// ---------------------------------------------------------------------------
module screen_scene_ctrl
  import gui_defs_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter bit SKIP_FADE       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_menu_in,
  input  logic [RGB_W-1:0] rgb_map_in,
  input  logic             start_req,
  input  logic             back_req,
  output logic [RGB_W-1:0] rgb_out,
  output logic             scene_sel,
  output logic             busy
);

  localparam logic [7:0] LAST_CNT = 8'(FRAMES_PER_STEP - 1);

  scene_state_e       state_q, state_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               pending_q, pending_d;
  logic               scene_sel_q, scene_sel_d;
  logic               busy_q, busy_d;
  logic               vblnk_q, vblnk_d;
  logic [RGB_W-1:0]   rgb_out_q, rgb_out_d;
  logic               fb_s;
  logic [RGB_W-1:0]   src_rgb_s;
  logic [RGB_W-1:0]   faded_rgb_s;

  // Frame boundary: first cycle of vertical blank.
  always_comb begin
    vblnk_d = vblnk_in;
    fb_s    = vblnk_in & ~vblnk_q;
  end

  // Scene FSM: request latching, fade step counting and scene swap.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    level_d     = level_q;
    pending_d   = pending_q;
    scene_sel_d = scene_sel_q;
    case (state_q)
      ST_MENU, ST_MAP: begin
        if (fb_s && pending_q) begin
          state_d     = ST_FADE_OUT;
          pending_d   = 1'b0;
          frame_cnt_d = 8'd0;
          level_d     = 3'd0;
        end else if ((state_q == ST_MENU) ? start_req : back_req) begin
          // Only the request meaningful for the current scene is latched.
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      ST_FADE_OUT: begin
        if (!fb_s) begin
          state_d = ST_FADE_OUT;
        end else if (SKIP_FADE) begin
          scene_sel_d = ~scene_sel_q;
          state_d     = scene_sel_q ? ST_MENU : ST_MAP;
        end else if (frame_cnt_q >= LAST_CNT) begin
          frame_cnt_d = 8'd0;
          if (level_q >= LEVEL_W'(FADE_LEVELS - 1)) begin
            // Fully black: swap scenes while nothing is visible.
            level_d     = LEVEL_W'(FADE_LEVELS);
            scene_sel_d = ~scene_sel_q;
            state_d     = ST_FADE_IN;
          end else begin
            level_d = level_q + 3'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_FADE_IN: begin
        if (!fb_s) begin
          state_d = ST_FADE_IN;
        end else if (frame_cnt_q >= LAST_CNT) begin
          frame_cnt_d = 8'd0;
          if (level_q <= 3'd1) begin
            level_d = 3'd0;
            state_d = scene_sel_q ? ST_MAP : ST_MENU;
          end else begin
            level_d = level_q - 3'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = ST_MENU;
        frame_cnt_d = 8'd0;
        level_d     = 3'd0;
        pending_d   = 1'b0;
        scene_sel_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_FADE_OUT) || (state_d == ST_FADE_IN);
  end

  // Pixel path: pick the active scene, dim it, force black in blanking.
  always_comb begin
    src_rgb_s = scene_sel_q ? rgb_map_in : rgb_menu_in;
    if (hblnk_in || vblnk_in) begin
      rgb_out_d = {RGB_W{1'b0}};
    end else begin
      rgb_out_d = faded_rgb_s;
    end
  end

  rgb_fade_shift u_fade (
    .rgb_in  (src_rgb_s),
    .level   (level_q),
    .rgb_out (faded_rgb_s)
  );

  // Control registers: edge detect, FSM state, counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      state_q     <= ST_MENU;
      frame_cnt_q <= 8'd0;
      level_q     <= 3'd0;
      pending_q   <= 1'b0;
      scene_sel_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vblnk_q     <= vblnk_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      level_q     <= level_d;
      pending_q   <= pending_d;
      scene_sel_q <= scene_sel_d;
      busy_q      <= busy_d;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out_q <= {RGB_W{1'b0}};
    end else begin
      rgb_out_q <= rgb_out_d;
    end
  end

  assign rgb_out   = rgb_out_q;
  assign scene_sel = scene_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_screen_scene_ctrl.sv
// ---------------------------------------------------------------------------
// tb_screen_scene_ctrl
// Three sequencers share one small video timing (16x8 pixels per frame):
//   idx 0: FRAMES_PER_STEP=1, fade      (directed scenarios)
//   idx 1: FRAMES_PER_STEP=1, SKIP_FADE (no-fade scenario)
//   idx 2: FRAMES_PER_STEP=3, fade      (random run only)
// A frame-level reference model describes each transition as "k frame
// boundaries since it started", from which level and scene follow.
// ---------------------------------------------------------------------------
module tb_screen_scene_ctrl;

  localparam int NI    = 3;
  localparam int H_TOT = 16;
  localparam int H_ACT = 10;
  localparam int V_TOT = 8;
  localparam int V_ACT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_menu_in = 12'h000;
  logic [11:0] rgb_map_in  = 12'h000;
  logic        start_req [NI];
  logic        back_req  [NI];
  logic [11:0] rgb_w     [NI];
  logic        scene_w   [NI];
  logic        busy_w    [NI];

  int tests = 0;
  int fails = 0;

  int          hcnt = 0, vcnt = 0, last_h = 0, last_v = 0;
  logic [11:0] menu_col = 12'hF84;
  logic [11:0] map_col  = 12'h0A5;
  bit          rand_pix = 1'b0;

  // reference model state
  int          k_m     [NI];
  bit          scene_m [NI];
  bit          pend_m  [NI];
  bit          vb_prev_m = 1'b0;
  logic [11:0] exp_rgb [NI];

  logic [11:0] up_pix   [9] = '{12'hF84, 12'h742, 12'h321, 12'h110, 12'h000,
                                12'h010, 12'h021, 12'h052, 12'h0A5};
  bit          up_scene [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [11:0] dn_pix   [9] = '{12'h0A5, 12'h052, 12'h021, 12'h010, 12'h000,
                                12'h110, 12'h321, 12'h742, 12'hF84};
  bit          dn_scene [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  bit          fade_busy[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  screen_scene_ctrl #(.FRAMES_PER_STEP(1), .SKIP_FADE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_menu_in(rgb_menu_in), .rgb_map_in(rgb_map_in),
    .start_req(start_req[0]), .back_req(back_req[0]),
    .rgb_out(rgb_w[0]), .scene_sel(scene_w[0]), .busy(busy_w[0]));

  screen_scene_ctrl #(.FRAMES_PER_STEP(1), .SKIP_FADE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_menu_in(rgb_menu_in), .rgb_map_in(rgb_map_in),
    .start_req(start_req[1]), .back_req(back_req[1]),
    .rgb_out(rgb_w[1]), .scene_sel(scene_w[1]), .busy(busy_w[1]));

  screen_scene_ctrl #(.FRAMES_PER_STEP(3), .SKIP_FADE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_menu_in(rgb_menu_in), .rgb_map_in(rgb_map_in),
    .start_req(start_req[2]), .back_req(back_req[2]),
    .rgb_out(rgb_w[2]), .scene_sel(scene_w[2]), .busy(busy_w[2]));

  function automatic int fps_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic bit skip_of(input int i);
    return (i == 1);
  endfunction

  // frame boundaries after the starting one at which the transition ends
  function automatic int done_k(input int i);
    return skip_of(i) ? 1 : 8 * fps_of(i);
  endfunction

  function automatic int model_level(input int i);
    int f;
    f = fps_of(i);
    if (k_m[i] < 0 || skip_of(i)) return 0;
    if (k_m[i] < 4 * f) return k_m[i] / f;
    return 4 - (k_m[i] - 4 * f) / f;
  endfunction

  function automatic bit model_scene(input int i);
    if (k_m[i] >= 0 && !skip_of(i) && k_m[i] >= 4 * fps_of(i)) return !scene_m[i];
    return scene_m[i];
  endfunction

  function automatic logic [11:0] dim(input logic [11:0] c, input int lvl);
    int d, r, g, b;
    d = 2 ** lvl;
    r = int'(c[11:8]) / d;
    g = int'(c[7:4]) / d;
    b = int'(c[3:0]) / d;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  // Drive one pixel clock of inputs, advance the model, wait for the next negedge.
  task automatic step();
    bit fb;
    hblnk_in = (hcnt >= H_ACT);
    vblnk_in = (vcnt >= V_ACT);
    if (rand_pix) begin
      rgb_menu_in = 12'($urandom);
      rgb_map_in  = 12'($urandom);
    end else begin
      rgb_menu_in = menu_col;
      rgb_map_in  = map_col;
    end
    last_h = hcnt;
    last_v = vcnt;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        k_m[i] = -1; scene_m[i] = 1'b0; pend_m[i] = 1'b0; exp_rgb[i] = 12'h000;
      end
      vb_prev_m = 1'b0;
    end else begin
      fb = vblnk_in && !vb_prev_m;
      for (int i = 0; i < NI; i++) begin
        exp_rgb[i] = (hblnk_in || vblnk_in) ? 12'h000
                   : dim(model_scene(i) ? rgb_map_in : rgb_menu_in, model_level(i));
        if (fb && k_m[i] >= 0) begin
          k_m[i]++;
          if (k_m[i] == done_k(i)) begin
            scene_m[i] = !scene_m[i];
            k_m[i] = -1;
          end
        end else if (fb && pend_m[i]) begin
          pend_m[i] = 1'b0;
          k_m[i] = 0;
        end else if (k_m[i] < 0 && ((!scene_m[i] && start_req[i]) || (scene_m[i] && back_req[i]))) begin
          pend_m[i] = 1'b1;
        end
      end
      vb_prev_m = vblnk_in;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      start_req[i] = 1'b0;
      back_req[i]  = 1'b0;
    end
    hcnt = hcnt + 1;
    if (hcnt == H_TOT) begin
      hcnt = 0;
      vcnt = (vcnt + 1) % V_TOT;
    end
  endtask

  // Step until the pixel just registered is (v,h); bounded.
  task automatic goto(input int v, input int h);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(last_v == v && last_h == h) && n < 400);
    if (!(last_v == v && last_h == h)) begin
      tests++; fails++;
      $display("FAIL goto_timeout: at v=%0d h=%0d, wanted v=%0d h=%0d", last_v, last_h, v, h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests += 3;
    if (rgb_w[0] !== 12'h000) begin fails++; $display("FAIL reset_rgb: got %h expected 000", rgb_w[0]); end
    if (scene_w[0] !== 1'b0) begin fails++; $display("FAIL reset_scene: got %b expected 0", scene_w[0]); end
    if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_w[0]); end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      goto(2, 4);
      tests += 3;
      if (rgb_w[0] !== 12'hF84) begin fails++; $display("FAIL idle_active_rgb: got %h expected F84", rgb_w[0]); end
      if (scene_w[0] !== 1'b0) begin fails++; $display("FAIL idle_scene: got %b expected 0", scene_w[0]); end
      if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy_w[0]); end
      goto(2, 12);
      tests++;
      if (rgb_w[0] !== 12'h000) begin fails++; $display("FAIL idle_hblank_rgb: got %h expected 000", rgb_w[0]); end
      goto(6, 3);
      tests++;
      if (rgb_w[0] !== 12'h000) begin fails++; $display("FAIL idle_vblank_rgb: got %h expected 000", rgb_w[0]); end
    end
  endtask

  task automatic test_fade_to_map();
    goto(2, 8);
    start_req[0] = 1'b1;
    step();
    goto(4, 15);
    tests++;
    if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL busy_before_fb: got %b expected 0", busy_w[0]); end
    step();
    tests++;
    if (busy_w[0] !== 1'b1) begin fails++; $display("FAIL busy_at_fb: got %b expected 1", busy_w[0]); end
    for (int i = 0; i < 9; i++) begin
      goto(2, 4);
      tests += 3;
      if (rgb_w[0] !== up_pix[i]) begin fails++; $display("FAIL fade_up_rgb[%0d]: got %h expected %h", i, rgb_w[0], up_pix[i]); end
      if (scene_w[0] !== up_scene[i]) begin fails++; $display("FAIL fade_up_scene[%0d]: got %b expected %b", i, scene_w[0], up_scene[i]); end
      if (busy_w[0] !== fade_busy[i]) begin fails++; $display("FAIL fade_up_busy[%0d]: got %b expected %b", i, busy_w[0], fade_busy[i]); end
      if (i == 3) begin
        goto(4, 15);
        tests++;
        if (scene_w[0] !== 1'b0) begin fails++; $display("FAIL scene_before_black_fb: got %b expected 0", scene_w[0]); end
        step();
        tests++;
        if (scene_w[0] !== 1'b1) begin fails++; $display("FAIL scene_at_black_fb: got %b expected 1", scene_w[0]); end
      end
      if (i == 6) back_req[0] = 1'b1;  // during fade-in: must be dropped
    end
    for (int f = 0; f < 2; f++) begin
      goto(2, 4);
      tests += 2;
      if (rgb_w[0] !== 12'h0A5) begin fails++; $display("FAIL map_settled_rgb: got %h expected 0A5", rgb_w[0]); end
      if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL map_settled_busy: got %b expected 0", busy_w[0]); end
    end
  endtask

  task automatic test_back_to_menu();
    goto(2, 8);
    start_req[0] = 1'b1;
    back_req[0]  = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      goto(2, 4);
      tests += 3;
      if (rgb_w[0] !== dn_pix[i]) begin fails++; $display("FAIL fade_dn_rgb[%0d]: got %h expected %h", i, rgb_w[0], dn_pix[i]); end
      if (scene_w[0] !== dn_scene[i]) begin fails++; $display("FAIL fade_dn_scene[%0d]: got %b expected %b", i, scene_w[0], dn_scene[i]); end
      if (busy_w[0] !== fade_busy[i]) begin fails++; $display("FAIL fade_dn_busy[%0d]: got %b expected %b", i, busy_w[0], fade_busy[i]); end
    end
    for (int f = 0; f < 3; f++) begin
      goto(2, 4);
      tests += 2;
      if (rgb_w[0] !== 12'hF84) begin fails++; $display("FAIL menu_settled_rgb: got %h expected F84", rgb_w[0]); end
      if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL no_second_transition: busy %b expected 0", busy_w[0]); end
    end
  endtask

  task automatic test_reset_mid_fade();
    goto(2, 8);
    start_req[0] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) goto(2, 4);
    tests++;
    if (rgb_w[0] !== 12'h321) begin fails++; $display("FAIL level2_rgb: got %h expected 321", rgb_w[0]); end
    goto(2, 6);
    rst = 1'b1;
    #1;
    tests += 3;
    if (rgb_w[0] !== 12'h000) begin fails++; $display("FAIL midfade_reset_rgb: got %h expected 000", rgb_w[0]); end
    if (scene_w[0] !== 1'b0) begin fails++; $display("FAIL midfade_reset_scene: got %b expected 0", scene_w[0]); end
    if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL midfade_reset_busy: got %b expected 0", busy_w[0]); end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (rgb_w[0] !== 12'hF84) begin fails++; $display("FAIL after_reset_rgb: got %h expected F84", rgb_w[0]); end
    for (int f = 0; f < 2; f++) begin
      goto(2, 4);
      tests += 2;
      if (rgb_w[0] !== 12'hF84) begin fails++; $display("FAIL after_reset_frame_rgb: got %h expected F84", rgb_w[0]); end
      if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL after_reset_busy: got %b expected 0", busy_w[0]); end
    end
  endtask

  task automatic test_skip_fade();
    goto(2, 8);
    start_req[1] = 1'b1;
    step();
    goto(4, 15);
    tests++;
    if (busy_w[1] !== 1'b0) begin fails++; $display("FAIL skip_busy_before: got %b expected 0", busy_w[1]); end
    step();
    tests += 2;
    if (busy_w[1] !== 1'b1) begin fails++; $display("FAIL skip_busy_start: got %b expected 1", busy_w[1]); end
    if (scene_w[1] !== 1'b0) begin fails++; $display("FAIL skip_scene_start: got %b expected 0", scene_w[1]); end
    goto(2, 4);
    tests += 2;
    if (rgb_w[1] !== 12'hF84) begin fails++; $display("FAIL skip_undimmed_rgb: got %h expected F84", rgb_w[1]); end
    if (busy_w[1] !== 1'b1) begin fails++; $display("FAIL skip_busy_frame: got %b expected 1", busy_w[1]); end
    goto(4, 15);
    tests++;
    if (scene_w[1] !== 1'b0) begin fails++; $display("FAIL skip_scene_before_swap: got %b expected 0", scene_w[1]); end
    step();
    tests += 2;
    if (scene_w[1] !== 1'b1) begin fails++; $display("FAIL skip_scene_swap: got %b expected 1", scene_w[1]); end
    if (busy_w[1] !== 1'b0) begin fails++; $display("FAIL skip_busy_end: got %b expected 0", busy_w[1]); end
    for (int f = 0; f < 2; f++) begin
      goto(2, 4);
      tests += 2;
      if (rgb_w[1] !== 12'h0A5) begin fails++; $display("FAIL skip_map_rgb: got %h expected 0A5", rgb_w[1]); end
      if (busy_w[1] !== 1'b0) begin fails++; $display("FAIL skip_map_busy: got %b expected 0", busy_w[1]); end
    end
  endtask

  task automatic test_random();
    rand_pix = 1'b1;
    for (int n = 0; n < 60 * H_TOT * V_TOT; n++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 299) == 0) start_req[i] = 1'b1;
        if ($urandom_range(0, 299) == 0) back_req[i]  = 1'b1;
      end
      step();
      for (int i = 0; i < NI; i++) begin
        tests += 3;
        if (rgb_w[i] !== exp_rgb[i]) begin
          fails++; $display("FAIL rand_rgb[%0d] cycle %0d: got %h expected %h", i, n, rgb_w[i], exp_rgb[i]);
        end
        if (scene_w[i] !== model_scene(i)) begin
          fails++; $display("FAIL rand_scene[%0d] cycle %0d: got %b expected %b", i, n, scene_w[i], model_scene(i));
        end
        if (busy_w[i] !== (k_m[i] >= 0)) begin
          fails++; $display("FAIL rand_busy[%0d] cycle %0d: got %b expected %b", i, n, busy_w[i], (k_m[i] >= 0));
        end
      end
    end
    rand_pix = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_req[i] = 1'b0;
      back_req[i]  = 1'b0;
      k_m[i]       = -1;
      scene_m[i]   = 1'b0;
      pend_m[i]    = 1'b0;
      exp_rgb[i]   = 12'h000;
    end
    test_reset();
    test_fade_to_map();
    test_back_to_menu();
    test_reset_mid_fade();
    test_skip_fade();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
